// File: rtl/valu_pkg.sv
// valu_pkg: op codes and legality helper for the vector ALU pipeline.
// Define VALU_DOT_EN to make op 101 (DOT) a legal operation.
package valu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_MIN = 3'b011,
    OP_MAX = 3'b100,
    OP_DOT = 3'b101
  } op_e;

  function automatic logic op_legal(input logic [2:0] op);
`ifdef VALU_DOT_EN
    return op <= OP_DOT;
`else
    return op <= OP_MAX;
`endif
  endfunction

endpackage

// File: rtl/valu_if.sv
// valu_if: operand/result handshake bundle of the vector ALU pipeline.
// master drives beats and consumes results; slave is the ALU side.
interface valu_if #(
  parameter int LANES  = 4,
  parameter int DATA_W = 32
);
  logic                    in_valid;
  logic                    in_ready;
  logic [2:0]              op;
  logic [LANES*DATA_W-1:0] a;
  logic [LANES*DATA_W-1:0] b;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*DATA_W-1:0] result;
  logic [LANES-1:0]        lane_zero;
  logic                    zero_flag;
  logic                    op_err;
  logic                    busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result,
    input  lane_zero, zero_flag, op_err, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result,
    output lane_zero, zero_flag, op_err, busy
  );
endinterface

// File: rtl/valu_lane.sv
// valu_lane: one lane of element-wise ADD/SUB/MUL/MIN/MAX.
// Other op codes yield 0; DOT and illegal ops are resolved in the top.
module valu_lane
  import valu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  logic a_lt_b;

  always_comb begin
    a_lt_b = $signed(a) < $signed(b);
    y      = '0;
    unique case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_MUL:  y = a * b;
      OP_MIN:  y = a_lt_b ? a : b;
      OP_MAX:  y = a_lt_b ? b : a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/vec_alu_pipe.sv
// vec_alu_pipe: LANES-wide vector ALU, STAGES-deep stall-as-a-whole pipe.
// Define VALU_DOT_EN to build the DOT reduction tree (lane 0 result).
module vec_alu_pipe
  import valu_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int DATA_W = 32,
  parameter int STAGES = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              op,
  input  logic [LANES*DATA_W-1:0] a,
  input  logic [LANES*DATA_W-1:0] b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] result,
  output logic [LANES-1:0]        lane_zero,
  output logic                    zero_flag,
  output logic                    op_err,
  output logic                    busy
);

  localparam int W = LANES * DATA_W;

  logic [W-1:0]      lane_y;
  logic [W-1:0]      comp;
  logic              comp_err;
  logic              adv;

  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] err_q, err_d;
  logic [W-1:0]      res_q [STAGES];
  logic [W-1:0]      res_d [STAGES];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    valu_lane #(.DATA_W(DATA_W)) u_lane (
      .op (op),
      .a  (a[i*DATA_W +: DATA_W]),
      .b  (b[i*DATA_W +: DATA_W]),
      .y  (lane_y[i*DATA_W +: DATA_W])
    );
  end

`ifdef VALU_DOT_EN
  logic [DATA_W-1:0] dot;

  always_comb begin
    dot = '0;
    for (int i = 0; i < LANES; i++)
      dot = dot + a[i*DATA_W +: DATA_W] * b[i*DATA_W +: DATA_W];
  end
`endif

  always_comb begin
    comp_err = !op_legal(op);
    comp     = lane_y;
`ifdef VALU_DOT_EN
    if (op == OP_DOT) comp = W'(dot);
`endif
    if (comp_err) comp = '0;
  end

  // The whole pipe moves together; bubbles carry zeroed data.
  assign adv = !vld_q[STAGES-1] || out_ready;

  always_comb begin
    vld_d = vld_q;
    err_d = err_q;
    for (int i = 0; i < STAGES; i++) res_d[i] = res_q[i];
    if (adv) begin
      vld_d[0] = in_valid;
      err_d[0] = in_valid && comp_err;
      res_d[0] = in_valid ? comp : '0;
      for (int i = 1; i < STAGES; i++) begin
        vld_d[i] = vld_q[i-1];
        err_d[i] = err_q[i-1];
        res_d[i] = res_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      err_q <= '0;
      for (int i = 0; i < STAGES; i++) res_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      err_q <= err_d;
      for (int i = 0; i < STAGES; i++) res_q[i] <= res_d[i];
    end
  end

  assign in_ready  = adv;
  assign out_valid = vld_q[STAGES-1];
  assign result    = res_q[STAGES-1];
  assign op_err    = out_valid && err_q[STAGES-1];
  assign busy      = |vld_q;

  always_comb begin
    for (int i = 0; i < LANES; i++)
      lane_zero[i] = out_valid && (result[i*DATA_W +: DATA_W] == '0);
  end

  assign zero_flag = out_valid && (&lane_zero);

endmodule

// File: tb/tb_vec_alu_pipe.sv
// tb_vec_alu_pipe: directed self-checking bench for vec_alu_pipe.
// Inputs change and outputs are read around the falling clock edge.
module tb_vec_alu_pipe;
  localparam int LANES  = 4;
  localparam int DATA_W = 32;
  localparam int W      = LANES * DATA_W;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  valu_if #(.LANES(LANES), .DATA_W(DATA_W)) vif ();

  vec_alu_pipe #(.LANES(LANES), .DATA_W(DATA_W), .STAGES(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (vif.in_valid),
    .in_ready  (vif.in_ready),
    .op        (vif.op),
    .a         (vif.a),
    .b         (vif.b),
    .out_valid (vif.out_valid),
    .out_ready (vif.out_ready),
    .result    (vif.result),
    .lane_zero (vif.lane_zero),
    .zero_flag (vif.zero_flag),
    .op_err    (vif.op_err),
    .busy      (vif.busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send_one(
    input  logic [2:0]   o,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] r,
    output logic         e,
    output logic [3:0]   lz,
    output logic         zf,
    output int           lat
  );
    @(negedge clk);
    vif.in_valid  = 1'b1;
    vif.op        = o;
    vif.a         = x;
    vif.b         = y;
    vif.out_ready = 1'b1;
    @(negedge clk);
    vif.in_valid = 1'b0;
    vif.op       = 3'b001;
    vif.a        = '1;
    vif.b        = '1;
    lat = 1;
    while (!vif.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    r  = vif.result;
    e  = vif.op_err;
    lz = vif.lane_zero;
    zf = vif.zero_flag;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (vif.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_out_valid got %b want 0", vif.out_valid);
    end
    n_cmp++;
    if (vif.result !== '0) begin
      n_bad++; $display("FAIL rst_result got %h want 0", vif.result);
    end
    n_cmp++;
    if ({vif.busy, vif.op_err, vif.zero_flag, vif.lane_zero} !== 7'b0) begin
      n_bad++;
      $display("FAIL rst_flags got %b want 0",
               {vif.busy, vif.op_err, vif.zero_flag, vif.lane_zero});
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (vif.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL rst_in_ready got %b want 1", vif.in_ready);
    end
  endtask

  task automatic test_add();
    logic [W-1:0] r; logic e; logic [3:0] lz; logic zf; int lat;
    send_one(3'b000, {32'hFFFFFFFF, 32'd3, 32'd2, 32'd1},
             {32'd1, 32'd1, 32'd1, 32'd1}, r, e, lz, zf, lat);
    n_cmp++;
    if (lat !== 3) begin
      n_bad++; $display("FAIL add_latency got %0d want 3", lat);
    end
    n_cmp++;
    if (r !== {32'd0, 32'd4, 32'd3, 32'd2}) begin
      n_bad++; $display("FAIL add_result got %h want 0/4/3/2", r);
    end
    n_cmp++;
    if ({lz, zf, e} !== {4'b1000, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL add_flags got lz=%b zf=%b err=%b want 1000/0/0", lz, zf, e);
    end
  endtask

  task automatic test_sub();
    logic [W-1:0] r; logic e; logic [3:0] lz; logic zf; int lat;
    send_one(3'b001, {4{32'd5}}, {4{32'd5}}, r, e, lz, zf, lat);
    n_cmp++;
    if (r !== '0) begin
      n_bad++; $display("FAIL sub_result got %h want 0", r);
    end
    n_cmp++;
    if ({lz, zf, e} !== {4'b1111, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL sub_flags got lz=%b zf=%b err=%b want 1111/1/0", lz, zf, e);
    end
    send_one(3'b001, {32'd0, 32'd0, 32'd1, 32'd9}, {32'd1, 32'd0, 32'd3, 32'd4},
             r, e, lz, zf, lat);
    n_cmp++;
    if (r !== {32'hFFFFFFFF, 32'd0, 32'hFFFFFFFE, 32'd5}) begin
      n_bad++; $display("FAIL sub_wrap got %h want ffffffff/0/fffffffe/5", r);
    end
  endtask

  task automatic test_mul();
    logic [W-1:0] r; logic e; logic [3:0] lz; logic zf; int lat;
    send_one(3'b010, {32'd2, 32'hFFFFFFFF, 32'h10000, 32'd3},
             {32'd0, 32'd2, 32'h10000, 32'd4}, r, e, lz, zf, lat);
    n_cmp++;
    if (r !== {32'd0, 32'hFFFFFFFE, 32'd0, 32'd12}) begin
      n_bad++; $display("FAIL mul_result got %h want 0/fffffffe/0/c", r);
    end
    n_cmp++;
    if ({lz, zf} !== {4'b1010, 1'b0}) begin
      n_bad++; $display("FAIL mul_flags got lz=%b zf=%b want 1010/0", lz, zf);
    end
  endtask

  task automatic test_minmax();
    logic [W-1:0] r; logic e; logic [3:0] lz; logic zf; int lat;
    logic [W-1:0] x, y;
    x = {32'd0, 32'd0, 32'd7, 32'hFFFFFFFF};
    y = {32'd0, 32'd0, 32'hFFFFFFFD, 32'd1};
    send_one(3'b011, x, y, r, e, lz, zf, lat);
    n_cmp++;
    if (r !== {32'd0, 32'd0, 32'hFFFFFFFD, 32'hFFFFFFFF}) begin
      n_bad++; $display("FAIL min_result got %h want 0/0/fffffffd/ffffffff", r);
    end
    send_one(3'b100, x, y, r, e, lz, zf, lat);
    n_cmp++;
    if (r !== {32'd0, 32'd0, 32'd7, 32'd1}) begin
      n_bad++; $display("FAIL max_result got %h want 0/0/7/1", r);
    end
  endtask

  task automatic test_illegal_dot();
    logic [W-1:0] r; logic e; logic [3:0] lz; logic zf; int lat;
    send_one(3'b111, {4{32'h12345678}}, {4{32'h9}}, r, e, lz, zf, lat);
    n_cmp++;
    if (r !== '0) begin
      n_bad++; $display("FAIL ill_result got %h want 0", r);
    end
    n_cmp++;
    if ({e, zf, lat} !== {1'b1, 1'b1, 32'd3}) begin
      n_bad++; $display("FAIL ill_flags got err=%b zf=%b lat=%0d want 1/1/3", e, zf, lat);
    end
    send_one(3'b110, {4{32'd3}}, {4{32'd3}}, r, e, lz, zf, lat);
    n_cmp++;
    if ({r, e} !== {{W{1'b0}}, 1'b1}) begin
      n_bad++; $display("FAIL ill110 got %h err=%b want 0 err=1", r, e);
    end
    send_one(3'b101, {32'd4, 32'd3, 32'd2, 32'd1}, {32'd4, 32'd3, 32'd2, 32'd1},
             r, e, lz, zf, lat);
`ifdef VALU_DOT_EN
    n_cmp++;
    if ({r, e} !== {96'd0, 32'd30, 1'b0}) begin
      n_bad++; $display("FAIL dot got %h err=%b want 1e err=0", r, e);
    end
`else
    n_cmp++;
    if ({r, e} !== {{W{1'b0}}, 1'b1}) begin
      n_bad++; $display("FAIL dot_off got %h err=%b want 0 err=1", r, e);
    end
`endif
    n_cmp++;
    if (lat !== 3) begin
      n_bad++; $display("FAIL dot_latency got %0d want 3", lat);
    end
  endtask

  task automatic test_back_to_back();
    int s, r, gaps, stall_c;
    bit prev_hold;
    logic [W-1:0] held, held_e;
    logic [W-1:0] expv;
    s = 0; r = 0; gaps = 0; stall_c = -1; prev_hold = 0;
    held = '0; held_e = '0; expv = '0;
    for (int c = 0; c < 40 && r < 10; c++) begin
      @(negedge clk);
      vif.out_ready = !(c >= 4 && c <= 7);
      vif.in_valid  = (s < 10);
      vif.op        = 3'b000;
      for (int i = 0; i < LANES; i++) begin
        vif.a[i*DATA_W +: DATA_W] = 32'(s * 16 + i);
        vif.b[i*DATA_W +: DATA_W] = 32'h100;
      end
      #1;
      if (!vif.in_ready && stall_c < 0) stall_c = c;
      if (prev_hold) begin
        n_cmp++;
        if (vif.out_valid !== 1'b1 || vif.result !== held ||
            {vif.lane_zero, vif.zero_flag, vif.op_err} !== held_e[5:0]) begin
          n_bad++;
          $display("FAIL b2b_hold c=%0d got %h want %h", c, vif.result, held);
        end
      end
      if (c >= 8 && !vif.out_valid) gaps++;
      if (vif.out_valid && vif.out_ready) begin
        for (int i = 0; i < LANES; i++)
          expv[i*DATA_W +: DATA_W] = 32'(r * 16 + i + 256);
        n_cmp++;
        if (vif.result !== expv) begin
          n_bad++; $display("FAIL b2b_beat%0d got %h want %h", r, vif.result, expv);
        end
        r++;
      end
      prev_hold = vif.out_valid && !vif.out_ready;
      held      = vif.result;
      held_e    = W'({vif.lane_zero, vif.zero_flag, vif.op_err});
      if (vif.in_valid && vif.in_ready) s++;
    end
    n_cmp++;
    if (r !== 10) begin
      n_bad++; $display("FAIL b2b_count got %0d want 10", r);
    end
    n_cmp++;
    if (stall_c !== 4) begin
      n_bad++; $display("FAIL b2b_in_ready_fall got cycle %0d want 4", stall_c);
    end
    n_cmp++;
    if (gaps !== 0) begin
      n_bad++; $display("FAIL b2b_gaps got %0d want 0", gaps);
    end
    @(negedge clk);
    vif.in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({vif.busy, vif.out_valid} !== 2'b00) begin
      n_bad++; $display("FAIL b2b_drain got busy=%b ov=%b want 0/0", vif.busy, vif.out_valid);
    end
  endtask

  task automatic test_reset_midflight();
    int seen;
    @(negedge clk);
    vif.out_ready = 1'b0;
    vif.in_valid  = 1'b1;
    vif.op        = 3'b000;
    vif.a         = {4{32'd11}};
    vif.b         = {4{32'd22}};
    @(negedge clk);
    vif.a = {4{32'd33}};
    @(negedge clk);
    vif.in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({vif.out_valid, vif.busy} !== 2'b11) begin
      n_bad++; $display("FAIL mid_pre got ov=%b busy=%b want 1/1", vif.out_valid, vif.busy);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({vif.out_valid, vif.busy} !== 2'b00) begin
      n_bad++; $display("FAIL mid_rst got ov=%b busy=%b want 0/0", vif.out_valid, vif.busy);
    end
    n_cmp++;
    if (vif.result !== '0) begin
      n_bad++; $display("FAIL mid_rst_result got %h want 0", vif.result);
    end
    @(negedge clk);
    rst = 1'b0;
    vif.out_ready = 1'b1;
    #1;
    n_cmp++;
    if (vif.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL mid_in_ready got %b want 1", vif.in_ready);
    end
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (vif.out_valid || vif.busy) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++; $display("FAIL mid_ghost got %0d cycles want 0", seen);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst           = 1'b1;
    vif.in_valid  = 1'b0;
    vif.op        = 3'b000;
    vif.a         = '0;
    vif.b         = '0;
    vif.out_ready = 1'b1;
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_minmax();
    test_illegal_dot();
    test_back_to_back();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
